cvxif_commit_buf: RTL and testbench

CVXIF_COMMIT_BUF -- requirements
Module: cvxif_commit_buf

---
 rtl/cvxif_pkg.sv | 30 +++
 rtl/cvxif_commit_buf.sv | 128 ++++++++++++
 tb/tb_cvxif_commit_buf.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF result/commit types, plus the commit-buffer entry state and default depth.
package cvxif_pkg;

  localparam int X_ID_WIDTH   = 4;
  localparam int X_DATA_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]   id;
    logic [X_DATA_WIDTH-1:0] data;
    logic [4:0]              rd;
    logic                    we;
    logic                    exc;
    logic [5:0]              exccode;
  } x_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_state_e;

  localparam int CVXIF_COMMIT_BUF_DEPTH = 4;

endpackage

// File: rtl/cvxif_commit_buf.sv
// In-order buffer holding coprocessor results until the core commits or kills them.
// Exception forwarding is enabled by defining CVXIF_COMMIT_BUF_EXC_EN.
module cvxif_commit_buf
  import cvxif_pkg::*;
#(
  parameter int DEPTH = CVXIF_COMMIT_BUF_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  x_result_t                    in_result_i,
  input  logic                         x_commit_valid_i,
  input  x_commit_t                    x_commit_i,
  output logic                         x_result_valid_o,
  input  logic                         x_result_ready_i,
  output x_result_t                    x_result_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_state_e            r_state [DEPTH];
  logic [X_ID_WIDTH-1:0]   r_id    [DEPTH];
  logic [X_DATA_WIDTH-1:0] r_data  [DEPTH];
  logic [4:0]              r_rd    [DEPTH];
  logic                    r_we    [DEPTH];
`ifdef CVXIF_COMMIT_BUF_EXC_EN
  logic                    r_exc     [DEPTH];
  logic [5:0]              r_exccode [DEPTH];
`endif

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic         w_push;
  logic         w_pop;
  logic         w_head_commit;
  logic         w_head_kill;
  entry_state_e w_commit_st;

  assign w_head_commit    = (r_state[r_rptr] == ST_COMMITTED);
  assign w_head_kill      = (r_state[r_rptr] == ST_KILLED);
  assign in_ready_o       = (r_count < DEPTH_C);
  assign w_push           = in_valid_i && in_ready_o;
  // A killed head drains silently; a committed head leaves only on handshake.
  assign w_pop            = w_head_kill || (w_head_commit && x_result_ready_i);
  assign w_commit_st      = x_commit_i.x_commit_kill ? ST_KILLED : ST_COMMITTED;
  assign x_result_valid_o = w_head_commit;
  assign occupancy_o      = r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (x_commit_valid_i && (r_state[i] == ST_PENDING) && (r_id[i] == x_commit_i.id))
          r_state[i] <= w_commit_st;
      end
      if (w_pop) begin
        r_state[r_rptr] <= ST_EMPTY;
        r_rptr          <= r_rptr + PW'(1);
      end
      // The write slot is always EMPTY when push is allowed, so it never collides with the pop.
      if (w_push) begin
        r_state[r_wptr] <= (x_commit_valid_i && (in_result_i.id == x_commit_i.id)) ?
                           w_commit_st : ST_PENDING;
        r_wptr          <= r_wptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id[r_wptr]      <= in_result_i.id;
      r_data[r_wptr]    <= in_result_i.data;
      r_rd[r_wptr]      <= in_result_i.rd;
      r_we[r_wptr]      <= in_result_i.we;
`ifdef CVXIF_COMMIT_BUF_EXC_EN
      r_exc[r_wptr]     <= in_result_i.exc;
      r_exccode[r_wptr] <= in_result_i.exccode;
`endif
    end
  end

  always_comb begin
    x_result_o = '0;
    if (w_head_commit) begin
      x_result_o.id      = r_id[r_rptr];
      x_result_o.data    = r_data[r_rptr];
      x_result_o.rd      = r_rd[r_rptr];
      x_result_o.we      = r_we[r_rptr];
`ifdef CVXIF_COMMIT_BUF_EXC_EN
      x_result_o.exc     = r_exc[r_rptr];
      x_result_o.exccode = r_exccode[r_rptr];
`endif
    end
  end

`ifndef CVXIF_COMMIT_BUF_EXC_EN
  logic w_unused_exc;
  assign w_unused_exc = ^{in_result_i.exc, in_result_i.exccode};
`endif

`ifndef SYNTHESIS
  logic w_dup;
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((r_state[i] != ST_EMPTY) && (r_id[i] == in_result_i.id)) w_dup = 1'b1;
  end

  a_push_unique_id: assert property (@(posedge clk_i) disable iff (!rst_ni) w_push |-> !w_dup);
  a_push_not_full:  assert property (@(posedge clk_i) disable iff (!rst_ni) in_valid_i |-> in_ready_o);
`endif

endmodule

// File: tb/tb_cvxif_commit_buf.sv
// Randomized and directed bench for cvxif_commit_buf against a queue-based reference model.
module tb_cvxif_commit_buf;
  import cvxif_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  x_result_t     in_result_i = '0;
  logic          x_commit_valid_i = 1'b0;
  x_commit_t     x_commit_i = '0;
  logic          x_result_valid_o;
  logic          x_result_ready_i = 1'b0;
  x_result_t     x_result_o;
  logic [CW-1:0] occupancy_o;

  always #5 clk_i = ~clk_i;

  cvxif_commit_buf #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_result_i      (in_result_i),
    .x_commit_valid_i (x_commit_valid_i),
    .x_commit_i       (x_commit_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_o       (x_result_o),
    .occupancy_o      (occupancy_o)
  );

  // Reference: queue of results in arrival order; st 0=pending, 1=committed, 2=killed.
  typedef struct {
    x_result_t r;
    int        st;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic x_result_t mk(input int id, input logic [31:0] data, input logic exc,
                                   input logic [5:0] code);
    x_result_t r;
    r         = '0;
    r.id      = X_ID_WIDTH'(id);
    r.data    = data;
    r.rd      = 5'(id + 1);
    r.we      = 1'b1;
    r.exc     = exc;
    r.exccode = code;
    return r;
  endfunction

  function automatic x_commit_t mkc(input int id, input logic kill);
    x_commit_t c;
    c.id            = X_ID_WIDTH'(id);
    c.x_commit_kill = kill;
    return c;
  endfunction

  function automatic x_result_t exp_res();
    x_result_t e;
    e = '0;
    if (q.size() > 0 && q[0].st == 1) begin
      e = q[0].r;
`ifndef CVXIF_COMMIT_BUF_EXC_EN
      e.exc     = 1'b0;
      e.exccode = '0;
`endif
    end
    return e;
  endfunction

  function automatic bit in_q(input int id);
    foreach (q[i]) if (int'(q[i].r.id) == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outs();
    chk("in_ready",  in_ready_o,       q.size() < DEPTH);
    chk("occupancy", occupancy_o,      q.size());
    chk("res_valid", x_result_valid_o, q.size() > 0 && q[0].st == 1);
    chk("res_data",  x_result_o,       exp_res());
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check at the next falling edge.
  task automatic step(input logic iv, input x_result_t ir, input logic cv, input x_commit_t c,
                      input logic rdy);
    bit can_push;
    in_valid_i       = iv;
    in_result_i      = ir;
    x_commit_valid_i = cv;
    x_commit_i       = c;
    x_result_ready_i = rdy;
    can_push = (q.size() < DEPTH);
    if (q.size() > 0 && (q[0].st == 2 || (q[0].st == 1 && rdy))) void'(q.pop_front());
    if (iv && can_push) q.push_back('{r: ir, st: 0});
    if (cv) foreach (q[i]) if (q[i].st == 0 && q[i].r.id == c.id) q[i].st = c.x_commit_kill ? 2 : 1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_outs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic push(input x_result_t r);
    step(1'b1, r, 1'b0, '0, 1'b0);
  endtask

  task automatic commit(input int id, input logic kill, input logic rdy);
    step(1'b0, '0, 1'b1, mkc(id, kill), rdy);
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    in_valid_i       = 1'b0;
    x_commit_valid_i = 1'b0;
    x_result_ready_i = 1'b0;
    @(posedge clk_i);
    q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("rst_valid", x_result_valid_o, 0);
    chk("rst_occ",   occupancy_o,      0);
    chk("rst_ready", in_ready_o,       1);
    chk("rst_data",  x_result_o,       0);
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();

    // Single push/commit/pop
    push(mk(3, 32'hA5, 1'b0, 6'd0));
    commit(3, 1'b0, 1'b1);
    chk("d1_id",   x_result_o.id,   3);
    chk("d1_data", x_result_o.data, 32'hA5);
    idle(1'b1);
    chk("d1_occ", occupancy_o, 0);

    // Out-of-order commit, in-order emission
    push(mk(1, 32'h11, 1'b0, 6'd0));
    push(mk(2, 32'h22, 1'b0, 6'd0));
    commit(2, 1'b0, 1'b0);
    chk("d2_blocked", x_result_valid_o, 0);
    commit(1, 1'b0, 1'b0);
    chk("d2_first", x_result_o.id, 1);
    idle(1'b1);
    chk("d2_second", x_result_o.id, 2);
    idle(1'b1);

    // Killed head dropped without a valid
    push(mk(1, 32'h31, 1'b0, 6'd0));
    push(mk(2, 32'h32, 1'b0, 6'd0));
    push(mk(3, 32'h33, 1'b0, 6'd0));
    commit(1, 1'b1, 1'b1);
    chk("d3_kill_novalid", x_result_valid_o, 0);
    commit(2, 1'b0, 1'b1);
    commit(3, 1'b0, 1'b1);
    repeat (3) idle(1'b1);

    // Fill, free one slot, wrap the write pointer
    do_reset();
    for (int i = 0; i < 4; i++) push(mk(i, 32'h40 + i, 1'b0, 6'd0));
    chk("d4_full", in_ready_o, 0);
    commit(0, 1'b0, 1'b1);
    chk("d4_still_full", in_ready_o, 0);
    idle(1'b1);
    chk("d4_ready", in_ready_o, 1);
    push(mk(4, 32'h44, 1'b0, 6'd0));
    for (int i = 1; i <= 4; i++) commit(i, 1'b0, 1'b1);
    repeat (3) idle(1'b1);

    // Back-pressure hold, then reset with an offered result
    push(mk(7, 32'hDEAD_BEEF, 1'b0, 6'd0));
    commit(7, 1'b0, 1'b0);
    repeat (5) idle(1'b0);
    chk("d5_hold", x_result_o.data, 32'hDEAD_BEEF);
    do_reset();

    // Exception fields
    push(mk(5, 32'h55, 1'b1, 6'd2));
    commit(5, 1'b0, 1'b0);
`ifdef CVXIF_COMMIT_BUF_EXC_EN
    chk("d6_exc",  x_result_o.exc,     1);
    chk("d6_code", x_result_o.exccode, 2);
`else
    chk("d6_exc",  x_result_o.exc,     0);
    chk("d6_code", x_result_o.exccode, 0);
`endif
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic      iv;
      logic      cv;
      logic      rdy;
      x_result_t r;
      x_commit_t c;
      int        id;
      iv = 1'b0;
      r  = '0;
      if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        id = $urandom_range(0, 15);
        while (in_q(id)) id = $urandom_range(0, 15);
        iv = 1'b1;
        r  = mk(id, $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      end
      cv = 1'($urandom_range(0, 1));
      c  = mkc($urandom_range(0, 15), $urandom_range(0, 3) == 0);
      if (iv && $urandom_range(0, 4) == 0) c.id = r.id;
      else if (q.size() > 0 && $urandom_range(0, 3) != 0) c.id = q[$urandom_range(0, q.size() - 1)].r.id;
      rdy = ($urandom_range(0, 9) < 6);
      step(iv, r, cv, c, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
